// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bit-cell quarter phases and R/W bit value.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        ACK_A = 3'd3,
        DATA  = 3'd4,
        ACK_D = 3'd5,
        STOP  = 3'd6
    } i2c_state_e;

    localparam logic [1:0] Q_LOW0  = 2'd0;
    localparam logic [1:0] Q_LOW1  = 2'd1;
    localparam logic [1:0] Q_HIGH0 = 2'd2;
    localparam logic [1:0] Q_HIGH1 = 2'd3;

    localparam logic I2C_WRITE = 1'b0;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-period tick generator: one-cycle pulse every CLK_DIV clocks while enabled.
module i2c_qtick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter parks at zero when disabled so every transaction starts on a full quarter.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/i2c_master_wr.sv
// Single-byte I2C write master: START, address+W, data byte, STOP, with ACK checks.
// SCL is driven push-pull; SDA is open-drain; one bit cell is four quarter ticks.
module i2c_master_wr #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       scl,
    inout  wire        sda
);

    import i2c_pkg::*;

    i2c_state_e state_q, state_d;
    logic [1:0] q_q, q_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       nack_q, nack_d;
    logic       scl_q, scl_d;
    logic       sda_oe_q, sda_oe_d;
    logic       qtick_en;
    logic       tick;

    assign qtick_en = (state_q != IDLE);

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk  (clk),
        .rst  (rst),
        .en   (qtick_en),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        nack_d  = nack_q;

        case (state_q)
            IDLE: begin
                // busy still high here means this is the cycle after done: drop it first.
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (req) begin
                    shift_d = {addr, I2C_WRITE};
                    data_d  = wdata;
                    nack_d  = 1'b0;
                    busy_d  = 1'b1;
                    q_d     = Q_LOW0;
                    state_d = START;
                end
            end
            default: begin
                if (tick) begin
                    q_d = q_q + 2'd1;
                    if (q_q == Q_HIGH0) begin
                        ack_d = sda;
                    end
                    if (q_q == Q_HIGH1) begin
                        case (state_q)
                            START: begin
                                bit_d   = 3'd7;
                                state_d = ADDR;
                            end
                            ADDR, DATA: begin
                                shift_d = {shift_q[6:0], 1'b0};
                                bit_d   = bit_q - 3'd1;
                                if (bit_q == 3'd0) begin
                                    state_d = (state_q == ADDR) ? ACK_A : ACK_D;
                                end
                            end
                            ACK_A: begin
                                if (ack_q) begin
                                    nack_d  = 1'b1;
                                    state_d = STOP;
                                end else begin
                                    shift_d = data_q;
                                    bit_d   = 3'd7;
                                    state_d = DATA;
                                end
                            end
                            ACK_D: begin
                                if (ack_q) begin
                                    nack_d = 1'b1;
                                end
                                state_d = STOP;
                            end
                            STOP: begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                            default: state_d = IDLE;
                        endcase
                    end
                end
            end
        endcase

        // Bus levels are registered from the next state, so they change on the quarter boundary.
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            START: sda_oe_d = (q_d == Q_HIGH0) || (q_d == Q_HIGH1);
            ADDR, DATA: begin
                scl_d    = q_d[1];
                sda_oe_d = ~shift_d[7];
            end
            ACK_A, ACK_D: scl_d = q_d[1];
            STOP: begin
                scl_d    = q_d[1];
                sda_oe_d = (q_d != Q_HIGH1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            q_q      <= 2'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            data_q   <= 8'd0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            nack_q   <= 1'b0;
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            nack_q   <= nack_d;
            scl_q    <= scl_d;
            sda_oe_q <= sda_oe_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign nack = nack_q;
    assign scl  = scl_q;
    assign sda  = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: behavioural slave plus bus monitor, table, random and corner sequences.
module tb_i2c_master_wr;

    localparam int         CLK_DIV    = 4;
    localparam logic [6:0] SLAVE_ADDR = 7'h50;
    localparam int         LAT_ACK    = 80 * CLK_DIV;
    localparam int         LAT_NACK   = 44 * CLK_DIV;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       req   = 1'b0;
    logic [6:0] addr  = 7'd0;
    logic [7:0] wdata = 8'd0;
    logic       busy, done, nack, scl;
    wire        sda;
    logic       slave_pull = 1'b0;

    pullup (sda);
    assign sda = slave_pull ? 1'b0 : 1'bz;

    i2c_master_wr #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .addr  (addr),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .nack  (nack),
        .scl   (scl),
        .sda   (sda)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave and monitor both look at the settled bus once per clock, on the falling edge.
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    int         s_bits = 0, s_byte = 0;
    logic       s_addressed = 1'b0;
    logic [7:0] s_sh = 8'd0;
    logic [7:0] rx_data = 8'd0;
    logic       force_data_nack = 1'b0;
    int         mon_starts = 0, mon_stops = 0, mon_rises = 0, mon_bits = 0;
    logic [7:0] mon_b0 = 8'd0, mon_b1 = 8'd0;

    always @(negedge clk) begin
        prev_scl <= scl;
        prev_sda <= sda;
        if (prev_scl && scl && prev_sda && !sda) begin
            mon_starts  <= mon_starts + 1;
            mon_bits    <= 0;
            s_bits      <= 0;
            s_byte      <= 0;
            s_addressed <= 1'b0;
            slave_pull  <= 1'b0;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            mon_stops  <= mon_stops + 1;
            s_bits     <= 0;
            slave_pull <= 1'b0;
        end else if (!prev_scl && scl) begin
            mon_rises <= mon_rises + 1;
            mon_bits  <= mon_bits + 1;
            if (mon_bits < 8) mon_b0 <= {mon_b0[6:0], sda};
            else if (mon_bits >= 9 && mon_bits < 17) mon_b1 <= {mon_b1[6:0], sda};
            if (s_bits < 8) begin
                s_sh   <= {s_sh[6:0], sda};
                s_bits <= s_bits + 1;
            end
        end else if (prev_scl && !scl) begin
            if (s_bits == 8) begin
                if (s_byte == 0) begin
                    s_addressed <= (s_sh[7:1] == SLAVE_ADDR) && (s_sh[0] == 1'b0);
                    slave_pull  <= (s_sh[7:1] == SLAVE_ADDR) && (s_sh[0] == 1'b0);
                end else if (s_addressed && !force_data_nack) begin
                    rx_data    <= s_sh;
                    slave_pull <= 1'b1;
                end
                s_bits <= 9;
            end else if (s_bits == 9) begin
                slave_pull <= 1'b0;
                s_bits     <= 0;
                s_byte     <= s_byte + 1;
            end
        end
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_lat(input string name, input int act, input int exp);
        n_tests++;
        if (act < exp - 1 || act > exp + 1) begin
            n_fail++;
            $display("FAIL %s: latency %0d expected %0d +/-1", name, act, exp);
        end
    endtask

    task automatic wait_busy(output bit ok);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!busy && n < 50);
        ok = busy;
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!done && n < 2000);
        ok = done;
    endtask

    task automatic run_txn(input logic [6:0] a, input logic [7:0] d, output logic got_nack,
                           output int lat, output int rises, output bit ok);
        int t0, r0;
        bit b;
        got_nack = 1'b0; lat = -1; rises = -1; ok = 1'b0;
        @(negedge clk);
        addr = a; wdata = d; req = 1'b1;
        wait_busy(b);
        req = 1'b0;
        if (!b) return;
        t0 = cyc; r0 = mon_rises;
        wait_done(b);
        if (!b) return;
        lat = cyc - t0; got_nack = nack; rises = mon_rises - r0; ok = 1'b1;
    endtask

    task automatic chk_idle(input string name, input logic exp_nack);
        repeat (3) @(negedge clk);
        chk({name, "_busy_low"}, 32'(busy), 32'd0);
        chk({name, "_scl_idle"}, 32'(scl), 32'd1);
        chk({name, "_sda_idle"}, 32'(sda), 32'd1);
        chk({name, "_nack_held"}, 32'(nack), 32'(exp_nack));
    endtask

    typedef struct {
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       exp_nack;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic       gn;
        int         lat, rises, s0, p0, t0, tda, dones;
        bit         ok;
        logic [6:0] ra;
        logic [7:0] rd, model_rx;
        logic       en;

        vecs[0] = '{7'h50, 8'hA5, 1'b0, 8'hA5};
        vecs[1] = '{7'h51, 8'h3C, 1'b1, 8'hA5};
        vecs[2] = '{7'h50, 8'h00, 1'b0, 8'h00};
        vecs[3] = '{7'h00, 8'h77, 1'b1, 8'h00};
        vecs[4] = '{7'h50, 8'hFF, 1'b0, 8'hFF};
        vecs[5] = '{7'h28, 8'h11, 1'b1, 8'hFF};
        vecs[6] = '{7'h7F, 8'h81, 1'b1, 8'hFF};

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_nack", 32'(nack), 32'd0);
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda", 32'(sda), 32'd1);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            s0 = mon_starts; p0 = mon_stops;
            run_txn(vecs[i].addr, vecs[i].wdata, gn, lat, rises, ok);
            chk($sformatf("vec%0d_done_seen", i), 32'(ok), 32'd1);
            chk($sformatf("vec%0d_nack", i), 32'(gn), 32'(vecs[i].exp_nack));
            chk_lat($sformatf("vec%0d_latency", i), lat, vecs[i].exp_nack ? LAT_NACK : LAT_ACK);
            chk($sformatf("vec%0d_scl_rises", i), 32'(rises), vecs[i].exp_nack ? 32'd10 : 32'd19);
            chk($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
            chk_idle($sformatf("vec%0d", i), vecs[i].exp_nack);
            if (i == 0) begin
                chk("mon_one_start", 32'(mon_starts - s0), 32'd1);
                chk("mon_one_stop", 32'(mon_stops - p0), 32'd1);
                chk("mon_byte0", 32'(mon_b0), 32'hA0);
                chk("mon_byte1", 32'(mon_b1), 32'hA5);
            end
        end

        // Randomised transactions against a plain address-match model of the slave.
        model_rx = rx_data;
        for (int k = 0; k < 8; k++) begin
            ra = ($urandom_range(0, 1) == 1) ? SLAVE_ADDR : 7'($urandom);
            rd = 8'($urandom);
            en = (ra != SLAVE_ADDR);
            if (!en) model_rx = rd;
            run_txn(ra, rd, gn, lat, rises, ok);
            chk($sformatf("rnd%0d_done_seen", k), 32'(ok), 32'd1);
            chk($sformatf("rnd%0d_nack", k), 32'(gn), 32'(en));
            chk_lat($sformatf("rnd%0d_latency", k), lat, en ? LAT_NACK : LAT_ACK);
            chk($sformatf("rnd%0d_rx_data", k), 32'(rx_data), 32'(model_rx));
        end

        // Data byte NACKed by the slave: full-length transaction, nack set.
        force_data_nack = 1'b1;
        run_txn(SLAVE_ADDR, 8'h99, gn, lat, rises, ok);
        force_data_nack = 1'b0;
        chk("dnack_nack", 32'(gn), 32'd1);
        chk_lat("dnack_latency", lat, LAT_ACK);
        chk("dnack_rx_unchanged", 32'(rx_data), 32'(model_rx));
        chk_idle("dnack", 1'b1);

        // Back-to-back with req held; wdata change after accept must not affect the first byte.
        @(negedge clk);
        addr = SLAVE_ADDR; wdata = 8'h3C; req = 1'b1;
        wait_busy(ok);
        chk("b2b_first_accept", 32'(ok), 32'd1);
        wdata = 8'hC3;
        wait_done(ok);
        tda = cyc;
        chk("b2b_first_done", 32'(ok), 32'd1);
        chk("b2b_first_nack", 32'(nack), 32'd0);
        chk("b2b_first_rx", 32'(rx_data), 32'h3C);
        @(posedge clk); #1;
        chk("b2b_gap_busy_low", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("b2b_second_accept", 32'(busy), 32'd1);
        chk("b2b_accept_gap", 32'(cyc - tda), 32'd2);
        t0 = cyc;
        req = 1'b0;
        wait_done(ok);
        chk("b2b_second_done", 32'(ok), 32'd1);
        chk_lat("b2b_second_latency", cyc - t0, LAT_ACK);
        chk("b2b_second_nack", 32'(nack), 32'd0);
        chk("b2b_rx_final", 32'(rx_data), 32'hC3);
        chk_idle("b2b", 1'b0);

        // req pulse with a different address in the middle of the DATA byte is ignored.
        @(negedge clk);
        addr = SLAVE_ADDR; wdata = 8'h6E; req = 1'b1;
        wait_busy(ok);
        req = 1'b0;
        t0 = cyc;
        while (cyc - t0 < 50 * CLK_DIV) @(posedge clk);
        @(negedge clk);
        addr = 7'h12; wdata = 8'h00; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        dones = 0; gn = 1'b1;
        for (int n = 0; n < 700; n++) begin
            @(posedge clk); #1;
            if (done) begin dones++; gn = nack; end
        end
        chk("ign_one_done", 32'(dones), 32'd1);
        chk("ign_nack", 32'(gn), 32'd0);
        chk("ign_rx", 32'(rx_data), 32'h6E);
        chk("ign_busy_low", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of the address byte.
        @(negedge clk);
        addr = SLAVE_ADDR; wdata = 8'h42; req = 1'b1;
        wait_busy(ok);
        req = 1'b0;
        repeat (20 * CLK_DIV) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_scl", 32'(scl), 32'd1);
        chk("arst_sda", 32'(sda), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        run_txn(SLAVE_ADDR, 8'h5A, gn, lat, rises, ok);
        chk("arst_after_done_seen", 32'(ok), 32'd1);
        chk("arst_after_nack", 32'(gn), 32'd0);
        chk_lat("arst_after_latency", lat, LAT_ACK);
        chk("arst_after_rx", 32'(rx_data), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
